// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan display: digit count,
// blank codes and the active-low hex glyph table ({g,f,e,d,c,b,a}).
package seg_pkg;

   localparam int NUM_DIGITS = 4;
   localparam int DIGIT_W    = $clog2(NUM_DIGITS);

   localparam logic [6:0] SEG_OFF = 7'h7F;
   localparam logic [3:0] AN_OFF  = 4'hF;

   // Entry n is the active-low pattern for hex digit n; listed F down to 0.
   localparam logic [15:0][6:0] SEG_TABLE = {
      7'h0E,   // F
      7'h06,   // E
      7'h21,   // d
      7'h46,   // C
      7'h03,   // b
      7'h08,   // A
      7'h10,   // 9
      7'h00,   // 8
      7'h78,   // 7
      7'h02,   // 6
      7'h12,   // 5
      7'h19,   // 4
      7'h30,   // 3
      7'h24,   // 2
      7'h79,   // 1
      7'h40    // 0
   };

endpackage

// File: rtl/seg_scan_display_hex_to_seg.sv
// Combinational hex nibble to active-low seven-segment pattern.
module hex_to_seg
   import seg_pkg::*;
(
   input  logic [3:0] hex_i,
   output logic [6:0] seg_o
);

   assign seg_o = SEG_TABLE[hex_i];

endmodule

// File: rtl/seg_scan_display.sv
// Multiplexed 4-digit hex display of one of four debug words, selected by a
// debounced push button. The shown word is snapshotted at each frame start so a
// frame never mixes two words.
// Optional build macro: SEG_BLANK_LEADING_ZERO_EN blanks leading zero digits
// (digit 0 always lit); scan timing is unchanged either way.
module seg_scan_display
   import seg_pkg::*;
#(
   parameter int SCAN_DIV        = 100000,
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic [15:0] word0_i,
   input  logic [15:0] word1_i,
   input  logic [15:0] word2_i,
   input  logic [15:0] word3_i,
   input  logic        sel_btn_i,
   output logic [1:0]  word_idx_o,
   output logic [3:0]  an_o,
   output logic [6:0]  seg_o
);

   localparam int SCAN_W = $clog2(SCAN_DIV);
   localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);

   logic                sync1_q, sync2_q;
   logic [DB_W-1:0]     db_cnt_q, db_cnt_d;
   logic                db_lvl_q, db_lvl_d;
   logic                rise_q, rise_d;
   logic [1:0]          word_idx_q, word_idx_d;
   logic [SCAN_W-1:0]   scan_cnt_q, scan_cnt_d;
   logic [DIGIT_W-1:0]  digit_q, digit_d;
   logic [15:0]         shown_q, shown_d;
   logic [3:0]          an_q, an_d;
   logic [6:0]          seg_q, seg_d;
   logic                frame_start;
   logic                blank;
   logic [3:0]          nibble;
   logic [6:0]          seg_dec;

   hex_to_seg u_hex_to_seg (
      .hex_i (nibble),
      .seg_o (seg_dec)
   );

   // Debounce: accept a new level after DEBOUNCE_CYCLES consecutive
   // disagreeing samples; a rising acceptance bumps word_idx one cycle later.
   always_comb begin
      db_cnt_d = db_cnt_q;
      db_lvl_d = db_lvl_q;
      rise_d   = 1'b0;
      if (sync2_q == db_lvl_q) begin
         db_cnt_d = '0;
      end else if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
         db_lvl_d = ~db_lvl_q;
         db_cnt_d = '0;
         rise_d   = ~db_lvl_q;
      end else begin
         db_cnt_d = db_cnt_q + 1'b1;
      end
      word_idx_d = rise_q ? word_idx_q + 2'd1 : word_idx_q;
   end

   // Scan timing and per-frame snapshot; snapshot uses the pre-increment index.
   always_comb begin
      frame_start = (scan_cnt_q == '0) && (digit_q == '0);
      scan_cnt_d  = scan_cnt_q + 1'b1;
      digit_d     = digit_q;
      if (scan_cnt_q == SCAN_W'(SCAN_DIV - 1)) begin
         scan_cnt_d = '0;
         digit_d    = digit_q + 1'b1;
      end
      shown_d = shown_q;
      if (frame_start) begin
         case (word_idx_q)
            2'd0:    shown_d = word0_i;
            2'd1:    shown_d = word1_i;
            2'd2:    shown_d = word2_i;
            default: shown_d = word3_i;
         endcase
      end
   end

   // Digit select, optional leading-zero blanking and next output pattern.
   always_comb begin
      case (digit_q)
         2'd0:    nibble = shown_q[3:0];
         2'd1:    nibble = shown_q[7:4];
         2'd2:    nibble = shown_q[11:8];
         default: nibble = shown_q[15:12];
      endcase
      blank = 1'b0;
`ifdef SEG_BLANK_LEADING_ZERO_EN
      case (digit_q)
         2'd1:    blank = (shown_q[15:4] == '0);
         2'd2:    blank = (shown_q[15:8] == '0);
         2'd3:    blank = (shown_q[15:12] == '0);
         default: blank = 1'b0;
      endcase
`endif
      an_d  = blank ? AN_OFF : ~(4'b0001 << digit_q);
      seg_d = blank ? SEG_OFF : seg_dec;
   end

   // Button synchronizer and debounce state.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         sync1_q    <= 1'b0;
         sync2_q    <= 1'b0;
         db_cnt_q   <= '0;
         db_lvl_q   <= 1'b0;
         rise_q     <= 1'b0;
         word_idx_q <= 2'd0;
      end else begin
         sync1_q    <= sel_btn_i;
         sync2_q    <= sync1_q;
         db_cnt_q   <= db_cnt_d;
         db_lvl_q   <= db_lvl_d;
         rise_q     <= rise_d;
         word_idx_q <= word_idx_d;
      end
   end

   // Scan position, snapshot and registered display outputs.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         scan_cnt_q <= '0;
         digit_q    <= '0;
         shown_q    <= 16'h0000;
         an_q       <= AN_OFF;
         seg_q      <= SEG_OFF;
      end else begin
         scan_cnt_q <= scan_cnt_d;
         digit_q    <= digit_d;
         shown_q    <= shown_d;
         an_q       <= an_d;
         seg_q      <= seg_d;
      end
   end

   assign word_idx_o = word_idx_q;
   assign an_o       = an_q;
   assign seg_o      = seg_q;

endmodule

// File: tb/tb_seg_scan_display.sv
// Self-checking bench for seg_scan_display with SCAN_DIV=4, DEBOUNCE_CYCLES=8.
// A cycle-position model predicts every output each cycle; directed steps pin
// hand-computed values at key moments.
module tb_seg_scan_display;

   localparam int SD = 4;
   localparam int DB = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [15:0] w0 = '0, w1 = '0, w2 = '0, w3 = '0;
   logic        sel_btn = 1'b0;
   logic [1:0]  word_idx;
   logic [3:0]  an;
   logic [6:0]  seg;

   int checks = 0;
   int errors = 0;
   bit chk_en = 0;

   seg_scan_display #(.SCAN_DIV(SD), .DEBOUNCE_CYCLES(DB)) dut (
      .clk_i      (clk),
      .rst_n_i    (rst_n),
      .word0_i    (w0),
      .word1_i    (w1),
      .word2_i    (w2),
      .word3_i    (w3),
      .sel_btn_i  (sel_btn),
      .word_idx_o (word_idx),
      .an_o       (an),
      .seg_o      (seg)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] hex_code(input logic [3:0] h);
      case (h)
         4'h0: return 7'b1000000;
         4'h1: return 7'b1111001;
         4'h2: return 7'b0100100;
         4'h3: return 7'b0110000;
         4'h4: return 7'b0011001;
         4'h5: return 7'b0010010;
         4'h6: return 7'b0000010;
         4'h7: return 7'b1111000;
         4'h8: return 7'b0000000;
         4'h9: return 7'b0010000;
         4'hA: return 7'b0001000;
         4'hB: return 7'b0000011;
         4'hC: return 7'b1000110;
         4'hD: return 7'b0100001;
         4'hE: return 7'b0000110;
         default: return 7'b0001110;
      endcase
   endfunction

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // Model: k = cycles since reset release; digit = (k/SD)%4; the shown word is
   // reloaded every 4*SD cycles; the button level flips after DB consecutive
   // disagreeing synchronized samples (raw value two cycles back).
   int          k;
   bit          hist[$];
   bit          lvl;
   int          lf;
   logic [1:0]  m_idx;
   bit          pend;
   logic [15:0] m_shown;
   logic [3:0]  e_an = 4'hF;
   logic [6:0]  e_seg = 7'h7F;

   always @(posedge clk or negedge rst_n) begin
      int d;
      bit blank;
      bit all_diff;
      if (!rst_n) begin
         k = 0; hist.delete(); lvl = 0; lf = -1000; m_idx = 0; pend = 0;
         m_shown = 16'h0; e_an = 4'hF; e_seg = 7'h7F;
      end else begin
         d = (k / SD) % 4;
         blank = 0;
`ifdef SEG_BLANK_LEADING_ZERO_EN
         blank = (d != 0) && ((m_shown >> (4 * d)) == 16'h0);
`endif
         e_an  = blank ? 4'hF : ~(4'b0001 << d);
         e_seg = blank ? 7'h7F : hex_code(4'((m_shown >> (4 * d)) & 16'hF));
         if (k % (4 * SD) == 0)
            m_shown = (m_idx == 0) ? w0 : (m_idx == 1) ? w1 : (m_idx == 2) ? w2 : w3;
         if (pend) m_idx = m_idx + 2'd1;
         pend = 0;
         hist.push_back(sel_btn);
         if (k >= DB + 1 && k - lf >= DB) begin
            all_diff = 1;
            for (int j = k - DB - 1; j <= k - 2; j++)
               if (hist[j] == lvl) all_diff = 0;
            if (all_diff) begin
               lvl = !lvl;
               lf = k;
               pend = lvl;
            end
         end
         k++;
      end
   end

   // Compare process: every cycle, half a period after the active edge.
   initial begin
      forever begin
         @(negedge clk);
         #1;
         if (chk_en) begin
            chk("model_an", {12'h0, an}, {12'h0, e_an});
            chk("model_seg", {9'h0, seg}, {9'h0, e_seg});
            chk("model_idx", {14'h0, word_idx}, {14'h0, m_idx});
         end
      end
   end

   task automatic tick();
      @(negedge clk);
      #2;
   endtask

   task automatic pin(input string name, input logic [3:0] ea, input logic [6:0] es);
      chk({name, "_an"}, {12'h0, an}, {12'h0, ea});
      chk({name, "_seg"}, {9'h0, seg}, {9'h0, es});
   endtask

   initial begin
      #1 rst_n = 1'b0;
      tick(); tick();
      pin("reset", 4'hF, 7'h7F);
      chk("reset_idx", {14'h0, word_idx}, 16'h0);
      chk_en = 1;

      // Scan of 16'h1234
      w0 = 16'h1234; w1 = 16'h5678; w2 = 16'h9ABC; w3 = 16'hDEF0;
      rst_n = 1'b1;
      tick();                         // after E0
      pin("first_cycle", 4'b1110, 7'b1000000);
      tick();                         // after E1
      pin("snap_d0", 4'b1110, 7'b0011001);
      repeat (3) tick();              // after E4
      pin("snap_d1", 4'b1101, 7'b0110000);
      repeat (8) tick();              // after E12
      pin("snap_d3", 4'b0111, 7'b1111001);

      // Bouncing button never settles long enough
      for (int i = 0; i < 10; i++) begin
         sel_btn = ~sel_btn;
         repeat (3) tick();
      end
      sel_btn = 1'b0;
      repeat (20) tick();
      chk("bounce_idx", {14'h0, word_idx}, 16'h0);

      // Clean presses: step 11 cycles after each rising edge
      for (int r = 0; r < 4; r++) begin
         sel_btn = 1'b1;
         repeat (10) tick();
         chk("press_hold", {14'h0, word_idx}, 16'(r));
         tick();
         chk("press_step", {14'h0, word_idx}, 16'((r + 1) % 4));
         repeat (9) tick();
         sel_btn = 1'b0;
         repeat (20) tick();
      end

      // Mid-frame index change only shows at next frame
      rst_n = 1'b0;
      tick();
      w0 = 16'hAAAA; w1 = 16'h5555;
      rst_n = 1'b1;
      sel_btn = 1'b1;
      repeat (11) tick();             // after E10
      chk("mid_idx", {14'h0, word_idx}, 16'h1);
      pin("mid_old", 4'b1011, 7'b0001000);
      repeat (6) tick();              // after E16
      pin("frame_edge_old", 4'b1110, 7'b0001000);
      tick();                         // after E17
      pin("next_frame_new", 4'b1110, 7'b0010010);
      repeat (2) tick();
      sel_btn = 1'b0;
      repeat (22) tick();             // after E41, digit 2

      // Reset mid-scan at digit 2
      pin("pre_rst_d2", 4'b1011, 7'b0010010);
      rst_n = 1'b0;
      #1;
      pin("async_rst", 4'hF, 7'h7F);
      chk("async_rst_idx", {14'h0, word_idx}, 16'h0);
      tick();
      w0 = 16'h0005;
      rst_n = 1'b1;
      tick();                         // after E0
      pin("restart", 4'b1110, 7'b1000000);

      // Leading-zero behaviour with 16'h0005 then 16'h0000
      tick();                         // after E1
      pin("w5_d0", 4'b1110, 7'b0010010);
      repeat (4) tick();              // after E5
`ifdef SEG_BLANK_LEADING_ZERO_EN
      pin("w5_d1", 4'hF, 7'h7F);
`else
      pin("w5_d1", 4'b1101, 7'b1000000);
`endif
      w0 = 16'h0000;
      repeat (12) tick();             // after E17
      pin("w0_d0", 4'b1110, 7'b1000000);
      repeat (4) tick();              // after E21
`ifdef SEG_BLANK_LEADING_ZERO_EN
      pin("w0_d1", 4'hF, 7'h7F);
`else
      pin("w0_d1", 4'b1101, 7'b1000000);
`endif
      repeat (20) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
